dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256, the number of 32-bit memory words (power of two).
REQ-002 SHALL have parameter LATENCY, default 2, the cycles from request accept to resp_valid assertion (legal range 1..15).
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  the reset, synchronous and active-high.
REQ-005 SHALL have port req_valid  input  1  the request-present signal from the processor.
REQ-006 SHALL have port req_ready  output  1  the signal that the responder accepts a request this cycle.
REQ-007 SHALL have port req_we  input  1  the operation select: 1 = store, 0 = load.
REQ-008 SHALL have port req_addr  input  32  the byte address.
REQ-009 SHALL have port req_size  input  2  the access size: 00 = byte, 01 = half, 10 = word, 11 = reserved.
REQ-010 SHALL have port req_unsigned  input  1  the load extension select: 1 = zero-extend, 0 = sign-extend.
REQ-011 SHALL have port req_wdata  input  32  the store data, with the operand in the low bits.
REQ-012 SHALL have port resp_valid  output  1  the response-present signal.
REQ-013 SHALL have port resp_ready  input  1  the processor's acceptance of the response.
REQ-014 SHALL have port resp_rdata  output  32  the extended load data; 0 for stores and errors.
REQ-015 SHALL have port resp_err  output  1  the access-fault flag.

Function
REQ-016 SHALL implement an FSM with the states IDLE, WAIT and RESP; only one request is outstanding at a time.
REQ-017 SHALL drive req_ready=1 only in IDLE and never while reset is high.
REQ-018 SHALL, in IDLE, capture we/addr/size/unsigned/wdata when req_valid and req_ready are both high at an edge, then enter WAIT with a down-counter loaded to LATENCY-1.
REQ-019 SHALL, in WAIT, decrement the counter each cycle; when it is 0, perform the access and enter RESP, so that resp_valid is first high exactly LATENCY cycles after the accept edge.
REQ-020 SHALL, in RESP, hold resp_valid, resp_rdata and resp_err stable until resp_ready is high at an edge, then return to IDLE; req_ready becomes 1 in the following cycle (minimum LATENCY+1 cycles per transaction).
REQ-021 SHALL flag an error (resp_err=1, resp_rdata=0, no memory write) for: half with addr[0]=1, word with addr[1:0]!=0, size 11, or addr[31:2] >= DEPTH_WORDS.
REQ-022 SHALL write stores only on the WAIT-to-RESP edge, updating only the addressed byte lanes: byte lane addr[1:0] gets wdata[7:0]; half lanes {addr[1],0}+1..+0 get wdata[15:0]; word gets all 4 lanes.
REQ-023 SHALL form load data from the addressed lanes, sign-extended from bit 7/15 when req_unsigned=0 and zero-extended when req_unsigned=1; req_unsigned is ignored for word loads.
REQ-024 SHALL give a load issued after a completed store to the same lanes the stored value (no stale read).
REQ-025 SHALL drive resp_err=0 and resp_rdata=0 for successful stores.
REQ-026 SHALL not sample req_* inputs outside the IDLE accept edge; changes in WAIT/RESP have no effect.

Reset
REQ-027 SHALL, while reset is high at an edge, force the state to IDLE, the counter to 0, and resp_valid=0, resp_rdata=0, resp_err=0, req_ready=0.
REQ-028 SHALL, on reset asserted in WAIT or RESP, drop the transaction; a store not yet written (still in WAIT) SHALL NOT modify memory.
REQ-029 SHALL not clear memory contents on reset; the contents are undefined until written.
REQ-030 SHALL drive req_ready=1 in the first cycle after reset deasserts.

Verification (LATENCY=2, DEPTH_WORDS=256)
REQ-031 SHALL cover: store word 0xDEADBEEF at 0x10, then load word 0x10 -> resp_rdata=0xDEADBEEF, resp_err=0, resp_valid high exactly 2 cycles after each accept.
REQ-032 SHALL cover: then store byte wdata=0x80 at 0x13 -> load byte signed 0x13 = 0xFFFFFF80; unsigned = 0x00000080; load word 0x10 = 0x80ADBEEF.
REQ-033 SHALL cover: load half at 0x11 and store word at 0x12 -> resp_err=1 and resp_rdata=0; a load word 0x10 afterwards still returns 0x80ADBEEF.
REQ-034 SHALL cover: load word 0x400 (index 256) and size=11 at 0x20 -> resp_err=1.
REQ-035 SHALL cover: hold resp_ready=0 for 5 cycles during a response -> resp_valid/resp_rdata/resp_err stable, req_ready=0 throughout, and a req_valid pulse in this window not accepted.
REQ-036 SHALL cover: store word 0x12345678 at 0x10 with reset asserted the cycle after accept -> outputs zero next cycle, req_ready=1 after release, and load 0x10 returns 0x80ADBEEF.

Source files
------------

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder: accepts one load/store, waits a fixed
// latency, performs the access on a word-organised byte-lane memory, then holds the response.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        we_q;
  logic [31:0] addr_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [31:0] wdata_q;

  logic [31:0] mem_q [DEPTH_WORDS];

  logic          accept;
  logic          mem_we;
  logic [AW-1:0] idx;
  logic          misalign;
  logic          out_of_range;
  logic          access_err;
  logic [31:0]   word_rd;
  logic [7:0]    byte_rd;
  logic [15:0]   half_rd;
  logic [31:0]   load_data;
  logic [3:0]    st_be;
  logic [31:0]   st_data;

  assign req_ready  = (state_q == IDLE) && !reset;
  assign accept     = req_valid && req_ready;
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

  assign idx          = addr_q[AW+1:2];
  assign out_of_range = addr_q[31:2] >= 30'(DEPTH_WORDS);
  assign access_err   = misalign || out_of_range;
  assign word_rd      = mem_q[idx];

  always_comb begin
    misalign = 1'b0;
    case (size_q)
      2'b00:   misalign = 1'b0;
      2'b01:   misalign = addr_q[0];
      2'b10:   misalign = |addr_q[1:0];
      default: misalign = 1'b1;
    endcase
  end

  always_comb begin
    byte_rd = word_rd[7:0];
    case (addr_q[1:0])
      2'd0:    byte_rd = word_rd[7:0];
      2'd1:    byte_rd = word_rd[15:8];
      2'd2:    byte_rd = word_rd[23:16];
      default: byte_rd = word_rd[31:24];
    endcase
    half_rd = addr_q[1] ? word_rd[31:16] : word_rd[15:0];

    load_data = word_rd;
    case (size_q)
      2'b00:   load_data = uns_q ? {24'd0, byte_rd} : {{24{byte_rd[7]}}, byte_rd};
      2'b01:   load_data = uns_q ? {16'd0, half_rd} : {{16{half_rd[15]}}, half_rd};
      default: load_data = word_rd;
    endcase
  end

  // Store data is replicated across lanes so the byte enables alone pick the target.
  always_comb begin
    st_be   = 4'b1111;
    st_data = wdata_q;
    case (size_q)
      2'b00: begin
        st_be   = 4'b0001 << addr_q[1:0];
        st_data = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        st_be   = addr_q[1] ? 4'b1100 : 4'b0011;
        st_data = {2{wdata_q[15:0]}};
      end
      default: begin
        st_be   = 4'b1111;
        st_data = wdata_q;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    mem_we  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = WAIT;
          cnt_d   = 4'(LATENCY - 1);
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
          err_d   = access_err;
          rdata_d = (access_err || we_q) ? '0 : load_data;
          mem_we  = we_q && !access_err && !reset;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_d = IDLE;
          rdata_d = '0;
          err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (accept) begin
        we_q    <= req_we;
        addr_q  <= req_addr;
        size_q  <= req_size;
        uns_q   <= req_unsigned;
        wdata_q <= req_wdata;
      end
    end
  end

  // Memory is deliberately outside the reset domain; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (st_be[i]) mem_q[idx][8*i +: 8] <= st_data[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder (LATENCY=2, DEPTH_WORDS=256): vector table plus
// hand-written backpressure and mid-transaction reset sequences.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_responder #(
    .DEPTH_WORDS(256),
    .LATENCY    (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_addr    (req_addr),
    .req_size    (req_size),
    .req_unsigned(req_unsigned),
    .req_wdata   (req_wdata),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_rdata  (resp_rdata),
    .resp_err    (resp_err)
  );

  typedef struct {
    string       name;
    logic        we;
    logic [31:0] addr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic add(input string name, input logic we, input logic [31:0] addr,
                     input logic [1:0] size, input logic uns, input logic [31:0] wdata,
                     input logic [31:0] exp_rdata, input logic exp_err);
    vec_t v;
    v.name = name; v.we = we; v.addr = addr; v.size = size; v.uns = uns;
    v.wdata = wdata; v.exp_rdata = exp_rdata; v.exp_err = exp_err;
    vecs.push_back(v);
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (!req_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check({name, "_ready_wait"}, 32'(req_ready), 32'd1);
  endtask

  // Issue one request and accept the response immediately; checks latency and data.
  task automatic run_txn(input vec_t v);
    int lat;
    wait_ready(v.name);
    req_valid = 1'b1; req_we = v.we; req_addr = v.addr; req_size = v.size;
    req_unsigned = v.uns; req_wdata = v.wdata;
    @(posedge clk); #1;
    req_valid = 1'b0;
    // scramble inputs after accept; they must not be sampled again
    req_we = ~v.we; req_addr = ~v.addr; req_size = ~v.size; req_unsigned = ~v.uns;
    req_wdata = ~v.wdata;
    lat = 0;
    while (!resp_valid && lat < 20) begin
      check({v.name, "_ready_low"}, 32'(req_ready), 32'd0);
      @(posedge clk); #1;
      lat++;
    end
    check({v.name, "_latency"}, 32'(lat), 32'd2);
    check({v.name, "_rdata"}, resp_rdata, v.exp_rdata);
    check({v.name, "_err"}, 32'(resp_err), 32'(v.exp_err));
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    check({v.name, "_ready_after"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    vec_t v;
    logic [31:0] held_rdata;
    int lat;

    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_size = '0;
    req_unsigned = 1'b0; req_wdata = '0; resp_ready = 1'b0;

    //   name          we    addr          size   uns   wdata          exp_rdata      err
    add("st_w10",      1'b1, 32'h10,       2'b10, 1'b0, 32'hDEADBEEF, 32'h0,         1'b0);
    add("ld_w10",      1'b0, 32'h10,       2'b10, 1'b0, 32'h0,        32'hDEADBEEF,  1'b0);
    add("st_b13",      1'b1, 32'h13,       2'b00, 1'b0, 32'h00000080, 32'h0,         1'b0);
    add("ld_bs13",     1'b0, 32'h13,       2'b00, 1'b0, 32'h0,        32'hFFFFFF80,  1'b0);
    add("ld_bu13",     1'b0, 32'h13,       2'b00, 1'b1, 32'h0,        32'h00000080,  1'b0);
    add("ld_w10b",     1'b0, 32'h10,       2'b10, 1'b0, 32'h0,        32'h80ADBEEF,  1'b0);
    add("ld_h11_mis",  1'b0, 32'h11,       2'b01, 1'b0, 32'h0,        32'h0,         1'b1);
    add("st_w12_mis",  1'b1, 32'h12,       2'b10, 1'b0, 32'hAAAAAAAA, 32'h0,         1'b1);
    add("ld_w10c",     1'b0, 32'h10,       2'b10, 1'b0, 32'h0,        32'h80ADBEEF,  1'b0);
    add("ld_w400_oor", 1'b0, 32'h400,      2'b10, 1'b0, 32'h0,        32'h0,         1'b1);
    add("ld_sz11",     1'b0, 32'h20,       2'b11, 1'b0, 32'h0,        32'h0,         1'b1);
    add("st_h22",      1'b1, 32'h22,       2'b01, 1'b0, 32'h1234ABCD, 32'h0,         1'b0);
    add("ld_hs22",     1'b0, 32'h22,       2'b01, 1'b0, 32'h0,        32'hFFFFABCD,  1'b0);
    add("ld_hu22",     1'b0, 32'h22,       2'b01, 1'b1, 32'h0,        32'h0000ABCD,  1'b0);
    add("ld_bs23",     1'b0, 32'h23,       2'b00, 1'b0, 32'h0,        32'hFFFFFFAB,  1'b0);
    add("st_b20",      1'b1, 32'h20,       2'b00, 1'b0, 32'hFFFFFF7F, 32'h0,         1'b0);
    add("ld_bs20",     1'b0, 32'h20,       2'b00, 1'b0, 32'h0,        32'h0000007F,  1'b0);
    add("st_w3fc",     1'b1, 32'h3FC,      2'b10, 1'b0, 32'h55AA00FF, 32'h0,         1'b0);
    add("ld_w3fc",     1'b0, 32'h3FC,      2'b10, 1'b0, 32'h0,        32'h55AA00FF,  1'b0);
    add("ld_wu10",     1'b0, 32'h10,       2'b10, 1'b1, 32'h0,        32'h80ADBEEF,  1'b0);
    add("ld_hi_oor",   1'b0, 32'h80000010, 2'b10, 1'b0, 32'h0,        32'h0,         1'b1);

    // Reset state
    repeat (3) begin
      @(posedge clk); #1;
      check("rst_req_ready", 32'(req_ready), 32'd0);
      check("rst_resp_valid", 32'(resp_valid), 32'd0);
      check("rst_resp_rdata", resp_rdata, 32'd0);
      check("rst_resp_err", 32'(resp_err), 32'd0);
    end
    reset = 1'b0;
    #1;
    check("rst_release_ready", 32'(req_ready), 32'd1);

    foreach (vecs[i]) run_txn(vecs[i]);

    // Backpressure: response held 5 cycles with a rejected store pulse in the window
    wait_ready("bp");
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_size = 2'b10; req_unsigned = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    while (!resp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("bp_latency", 32'(lat), 32'd2);
    held_rdata = resp_rdata;
    check("bp_rdata", held_rdata, 32'h80ADBEEF);
    for (int c = 0; c < 5; c++) begin
      if (c == 2) begin
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h10; req_size = 2'b10;
        req_wdata = 32'hCAFEF00D;
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
      check("bp_valid_hold", 32'(resp_valid), 32'd1);
      check("bp_rdata_hold", resp_rdata, held_rdata);
      check("bp_err_hold", 32'(resp_err), 32'd0);
      check("bp_ready_low", 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    check("bp_ready_after", 32'(req_ready), 32'd1);
    check("bp_valid_drop", 32'(resp_valid), 32'd0);
    v.name = "bp_reload"; v.we = 1'b0; v.addr = 32'h10; v.size = 2'b10; v.uns = 1'b0;
    v.wdata = '0; v.exp_rdata = 32'h80ADBEEF; v.exp_err = 1'b0;
    run_txn(v);

    // Reset the cycle after accepting a store: store must be dropped
    wait_ready("rs");
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h10; req_size = 2'b10;
    req_wdata = 32'h12345678;
    @(posedge clk); #1;
    req_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    check("rs_valid", 32'(resp_valid), 32'd0);
    check("rs_rdata", resp_rdata, 32'd0);
    check("rs_err", 32'(resp_err), 32'd0);
    check("rs_ready_in_reset", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    check("rs_valid2", 32'(resp_valid), 32'd0);
    reset = 1'b0;
    #1;
    check("rs_ready_release", 32'(req_ready), 32'd1);
    v.name = "rs_reload"; v.exp_rdata = 32'h80ADBEEF;
    run_txn(v);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
